// File: rtl/bp_pkg.sv
// Shared definitions for the tournament branch predictor: 2-bit counter encodings
// and the saturating counter step.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctrT;

    // One saturating step of a 2-bit counter toward the resolved direction
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// 2^DEPTH x 2-bit saturating counter table: one combinational read port,
// one synchronous update port, async active-low reset of every entry to WNT.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] rdIdx,
    output logic [1:0]       rdCnt_c,
    input  logic             updEn,
    input  logic [DEPTH-1:0] updIdx,
    input  logic             updTaken
);

    localparam int unsigned ENTRIES = 2 ** DEPTH;

    logic [1:0] cnt [ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= WNT;
        end else if (updEn) begin
            cnt[updIdx] <= sat_update(cnt[updIdx], updTaken);
        end
    end

    // Reads see pre-edge contents; no bypass of a same-cycle update
    assign rdCnt_c = cnt[rdIdx];

endmodule

// File: rtl/bp_tournament.sv
// Tournament direction predictor: gshare global + two-level local, chosen per index.
// Optional BP_STATS_EN adds saturating branch / mispredict counters.
module bp_tournament
    import bp_pkg::*;
#(
    parameter  int unsigned GPHT_DEPTH = 7,
    parameter  int unsigned GHR_WIDTH  = 4,
    parameter  int unsigned BHT_DEPTH  = 3,
    parameter  int unsigned LHIST_W    = 4,
    localparam int unsigned META_W     = GPHT_DEPTH + BHT_DEPTH + LHIST_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_f,
    output logic              pred_taken_f,
    output logic [META_W-1:0] pred_meta_f,
    input  logic              upd_valid,
    input  logic              upd_taken,
    input  logic              upd_pred,
    input  logic [META_W-1:0] upd_meta,
    output logic              mispredict,
    output logic              flush_e,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int unsigned BHT_ENTRIES = 2 ** BHT_DEPTH;

    typedef struct packed {
        logic [GPHT_DEPTH-1:0] gidx;
        logic [BHT_DEPTH-1:0]  bidx;
        logic [LHIST_W-1:0]    lhist;
        logic                  predG;
        logic                  predL;
    } metaT;

    logic [GHR_WIDTH-1:0]  ghr;
    logic [LHIST_W-1:0]    bht [BHT_ENTRIES];
    logic [GPHT_DEPTH-1:0] gidxF;
    logic [BHT_DEPTH-1:0]  bidxF;
    logic [LHIST_W-1:0]    lhistF;
    logic [1:0]            gCnt;
    logic [1:0]            lCnt;
    logic [1:0]            cCnt;
    metaT                  updMeta;
    logic                  unusedBits;

    // Fetch-side index generation
    assign gidxF  = pc_f[GPHT_DEPTH+1:2] ^ GPHT_DEPTH'(ghr);
    assign bidxF  = pc_f[BHT_DEPTH+1:2];
    assign lhistF = bht[bidxF];

    assign pred_taken_f = cCnt[1] ? lCnt[1] : gCnt[1];
    assign pred_meta_f  = {gidxF, bidxF, lhistF, gCnt[1], lCnt[1]};

    assign updMeta    = metaT'(upd_meta);
    assign mispredict = upd_valid & (upd_taken ^ upd_pred);
    assign flush_e    = mispredict;

    bp_pht #(.DEPTH(GPHT_DEPTH)) u_gpht (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (gidxF),
        .rdCnt_c  (gCnt),
        .updEn    (upd_valid),
        .updIdx   (updMeta.gidx),
        .updTaken (upd_taken)
    );

    bp_pht #(.DEPTH(LHIST_W)) u_lpht (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (lhistF),
        .rdCnt_c  (lCnt),
        .updEn    (upd_valid),
        .updIdx   (updMeta.lhist),
        .updTaken (upd_taken)
    );

    // Chooser moves only when the two components disagreed; exactly one was right
    bp_pht #(.DEPTH(GPHT_DEPTH)) u_cpht (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (gidxF),
        .rdCnt_c  (cCnt),
        .updEn    (upd_valid & (updMeta.predG ^ updMeta.predL)),
        .updIdx   (updMeta.gidx),
        .updTaken (updMeta.predL == upd_taken)
    );

    // Global and local histories; the oldest bit falls off the top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= '0;
        end else if (upd_valid) begin
            ghr                <= GHR_WIDTH'({ghr, upd_taken});
            bht[updMeta.bidx]  <= LHIST_W'({bht[updMeta.bidx], upd_taken});
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else begin
            if (upd_valid && (branchCnt != '1))   branchCnt  <= branchCnt + 32'd1;
            if (mispredict && (mispredCnt != '1)) mispredCnt <= mispredCnt + 32'd1;
        end
    end

    assign stat_branches = branchCnt;
    assign stat_mispred  = mispredCnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

    assign unusedBits = ^{pc_f[31:GPHT_DEPTH+2], pc_f[1:0], gCnt[0], lCnt[0], cCnt[0]};

endmodule

// File: tb/tb_bp_tournament.sv
// Self-checking bench for bp_tournament against an integer-array reference model.
module tb_bp_tournament;

    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_f;
    logic          pred_taken_f;
    logic [MW-1:0] pred_meta_f;
    logic          upd_valid;
    logic          upd_taken;
    logic          upd_pred;
    logic [MW-1:0] upd_meta;
    logic          mispredict;
    logic          flush_e;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispred;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    bp_tournament #(
        .GPHT_DEPTH(7), .GHR_WIDTH(4), .BHT_DEPTH(3), .LHIST_W(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .pred_meta_f(pred_meta_f), .upd_valid(upd_valid), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .upd_meta(upd_meta), .mispredict(mispredict),
        .flush_e(flush_e), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    // Reference model: counters kept as integers 0..3, histories as integers
    int mG [128];
    int mL [16];
    int mC [128];
    int mB [8];
    int mGhr;
    longint mBr;
    longint mMp;
    int uG, uB, uL, uM;
    bit uT, uPg, uPl;

    function automatic int satStep(int c, bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic int gidxOf(logic [31:0] pc);
        return ((int'(pc >> 2)) ^ mGhr) & 127;
    endfunction

    function automatic logic [15:0] mMeta(logic [31:0] pc);
        int g = gidxOf(pc);
        int b = int'(pc >> 2) & 7;
        int lh = mB[b];
        int pg = (mG[g] >= 2) ? 1 : 0;
        int pl = (mL[lh] >= 2) ? 1 : 0;
        return 16'(g * 512 + b * 64 + lh * 4 + pg * 2 + pl);
    endfunction

    function automatic bit mPred(logic [31:0] pc);
        logic [15:0] m = mMeta(pc);
        return (mC[gidxOf(pc)] >= 2) ? m[0] : m[1];
    endfunction

    function automatic logic [31:0] expStat(longint v);
`ifdef BP_STATS_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) begin mG[i] <= 1; mC[i] <= 1; end
            for (int i = 0; i < 16; i++) mL[i] <= 1;
            for (int i = 0; i < 8; i++) mB[i] <= 0;
            mGhr <= 0; mBr <= 0; mMp <= 0;
        end else if (upd_valid) begin
            uM = int'(upd_meta); uT = upd_taken;
            uG = (uM >> 9) & 127; uB = (uM >> 6) & 7; uL = (uM >> 2) & 15;
            uPg = upd_meta[1]; uPl = upd_meta[0];
            mG[uG] <= satStep(mG[uG], uT);
            mL[uL] <= satStep(mL[uL], uT);
            mB[uB] <= ((mB[uB] << 1) | int'(uT)) & 15;
            mGhr   <= ((mGhr << 1) | int'(uT)) & 15;
            if (uPg != uT && uPl == uT) mC[uG] <= satStep(mC[uG], 1'b1);
            else if (uPl != uT && uPg == uT) mC[uG] <= satStep(mC[uG], 1'b0);
            mBr <= mBr + 1;
            if (upd_taken != upd_pred) mMp <= mMp + 1;
        end
    end

    task automatic pulseReset();
        @(negedge clk);
        upd_valid = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [MW-1:0] m;
        rst = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; upd_pred = 1'b0;
        upd_meta = '0; pc_f = 32'h0040_0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        m = pred_meta_f;
        nChecks++; if (pred_taken_f !== 1'b0) $display("FAIL reset_pred got %b exp 0", pred_taken_f); else nPass++;
        nChecks++; if (m[5:2] !== 4'd0) $display("FAIL reset_lhist got %0h exp 0", m[5:2]); else nPass++;
        nChecks++; if (m !== 16'h0000) $display("FAIL reset_meta got %h exp 0000", m); else nPass++;
        nChecks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %b exp 0", mispredict); else nPass++;
        nChecks++; if (flush_e !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush_e); else nPass++;
        nChecks++; if (stat_branches !== 32'd0) $display("FAIL reset_stat_br got %0d exp 0", stat_branches); else nPass++;
        nChecks++; if (stat_mispred !== 32'd0) $display("FAIL reset_stat_mp got %0d exp 0", stat_mispred); else nPass++;
    endtask

    task automatic test_mispredict();
        @(negedge clk);
        pc_f = 32'h0040_0000; upd_meta = mMeta(pc_f);
        upd_valid = 1'b1; upd_pred = 1'b0; upd_taken = 1'b1;
        #1;
        nChecks++; if (mispredict !== 1'b1) $display("FAIL mp_set got %b exp 1", mispredict); else nPass++;
        nChecks++; if (flush_e !== 1'b1) $display("FAIL mp_flush_set got %b exp 1", flush_e); else nPass++;
        upd_valid = 1'b0;
        #1;
        nChecks++; if (mispredict !== 1'b0) $display("FAIL mp_novalid got %b exp 0", mispredict); else nPass++;
        nChecks++; if (flush_e !== 1'b0) $display("FAIL mp_flush_novalid got %b exp 0", flush_e); else nPass++;
        upd_valid = 1'b1; upd_pred = 1'b1;
        #1;
        nChecks++; if (mispredict !== 1'b0) $display("FAIL mp_correct got %b exp 0", mispredict); else nPass++;
        upd_valid = 1'b0;
    endtask

    task automatic test_learning();
        logic [31:0] pc = 32'h0040_0010;
        logic [MW-1:0] em;
        bit ep;
        pulseReset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pc_f = pc; em = mMeta(pc); ep = mPred(pc);
            upd_meta = em; upd_pred = ep; upd_taken = 1'b1; upd_valid = 1'b1;
            #1;
            nChecks++; if (pred_taken_f !== ep) $display("FAIL learn_pred[%0d] got %b exp %b", k, pred_taken_f, ep); else nPass++;
            nChecks++; if (pred_meta_f !== em) $display("FAIL learn_meta[%0d] got %h exp %h", k, pred_meta_f, em); else nPass++;
            if (k >= 6) begin
                nChecks++; if (pred_taken_f !== 1'b1) $display("FAIL learn_trained[%0d] got %b exp 1", k, pred_taken_f); else nPass++;
            end
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [MW-1:0] m;
        @(negedge clk);
        upd_meta = 16'hAA00; upd_taken = 1'b1; upd_pred = 1'b1; upd_valid = 1'b1;
        pc_f = 32'h0040_0000;
        repeat (4) @(negedge clk);
        @(negedge clk);
        upd_taken = 1'b0;
        pc_f = 32'h0040_0168;
        #1;
        m = pred_meta_f;
        nChecks++; if (m[15:9] !== 7'h55) $display("FAIL sat_gidx got %h exp 55", m[15:9]); else nPass++;
        nChecks++; if (m[1] !== 1'b1) $display("FAIL sat_predg_high got %b exp 1", m[1]); else nPass++;
        @(negedge clk);
        upd_valid = 1'b0;
        pc_f = 32'h0040_016C;
        #1;
        m = pred_meta_f;
        nChecks++; if (m[15:9] !== 7'h55) $display("FAIL sat_gidx2 got %h exp 55", m[15:9]); else nPass++;
        nChecks++; if (m[1] !== 1'b1) $display("FAIL sat_predg_after_nt got %b exp 1", m[1]); else nPass++;
        nChecks++; if (pred_taken_f !== mPred(pc_f)) $display("FAIL sat_pred got %b exp %b", pred_taken_f, mPred(pc_f)); else nPass++;
    endtask

    task automatic test_chooser();
        logic [MW-1:0] m;
        pulseReset();
        @(negedge clk);
        upd_meta = 16'h4201; upd_taken = 1'b1; upd_pred = 1'b0; upd_valid = 1'b1;
        @(negedge clk);
        upd_meta = 16'h4217; upd_taken = 1'b0; upd_pred = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0; pc_f = 32'h0040_008C;
        #1;
        m = pred_meta_f;
        nChecks++; if (m[1:0] !== 2'b01) $display("FAIL ch_fwd_components got %b exp 01", m[1:0]); else nPass++;
        nChecks++; if (pred_taken_f !== 1'b1) $display("FAIL ch_fwd_selects_local got %b exp 1", pred_taken_f); else nPass++;
        pulseReset();
        @(negedge clk);
        upd_meta = 16'h8026; upd_taken = 1'b1; upd_pred = 1'b1; upd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        upd_valid = 1'b0; pc_f = 32'h0040_010C;
        #1;
        m = pred_meta_f;
        nChecks++; if (m[1:0] !== 2'b10) $display("FAIL ch_rev_components got %b exp 10", m[1:0]); else nPass++;
        nChecks++; if (pred_taken_f !== 1'b1) $display("FAIL ch_rev_selects_global got %b exp 1", pred_taken_f); else nPass++;
    endtask

    task automatic test_random();
        logic [31:0] pcs [8];
        int bias [8];
        int s;
        logic [MW-1:0] em;
        bit ep, em_mp;
        for (int i = 0; i < 8; i++) begin
            pcs[i]  = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            bias[i] = (i < 3) ? 90 : ((i < 5) ? 10 : 50);
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            s = $urandom_range(0, 7);
            pc_f = pcs[s]; em = mMeta(pc_f); ep = mPred(pc_f);
            upd_meta  = em;
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_taken = ($urandom_range(0, 99) < bias[s]);
            upd_pred  = ($urandom_range(0, 7) == 0) ? ~ep : ep;
            em_mp = upd_valid & (upd_taken ^ upd_pred);
            #1;
            nChecks++; if (pred_taken_f !== ep) $display("FAIL rnd_pred[%0d] got %b exp %b", n, pred_taken_f, ep); else nPass++;
            nChecks++; if (pred_meta_f !== em) $display("FAIL rnd_meta[%0d] got %h exp %h", n, pred_meta_f, em); else nPass++;
            nChecks++; if (mispredict !== em_mp) $display("FAIL rnd_mispredict[%0d] got %b exp %b", n, mispredict, em_mp); else nPass++;
            nChecks++; if (flush_e !== em_mp) $display("FAIL rnd_flush[%0d] got %b exp %b", n, flush_e, em_mp); else nPass++;
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        nChecks++; if (stat_branches !== expStat(mBr)) $display("FAIL rnd_stat_br got %0d exp %0d", stat_branches, expStat(mBr)); else nPass++;
        nChecks++; if (stat_mispred !== expStat(mMp)) $display("FAIL rnd_stat_mp got %0d exp %0d", stat_mispred, expStat(mMp)); else nPass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] pc = 32'h0040_0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pc_f = pc; upd_meta = mMeta(pc); upd_pred = mPred(pc);
            upd_taken = 1'b1; upd_valid = 1'b1;
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        nChecks++; if (pred_taken_f !== 1'b1) $display("FAIL ar_trained got %b exp 1", pred_taken_f); else nPass++;
        #2 rst = 1'b0;
        #1;
        nChecks++; if (pred_taken_f !== 1'b0) $display("FAIL ar_pred got %b exp 0", pred_taken_f); else nPass++;
        nChecks++; if (pred_meta_f !== 16'h0900) $display("FAIL ar_meta got %h exp 0900", pred_meta_f); else nPass++;
        nChecks++; if (stat_branches !== 32'd0) $display("FAIL ar_stat_br got %0d exp 0", stat_branches); else nPass++;
        nChecks++; if (stat_mispred !== 32'd0) $display("FAIL ar_stat_mp got %0d exp 0", stat_mispred); else nPass++;
        upd_meta = 16'h0900; upd_taken = 1'b1; upd_pred = 1'b0; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        nChecks++; if (pred_meta_f !== 16'h0900) $display("FAIL ar_ignored_update got %h exp 0900", pred_meta_f); else nPass++;
        nChecks++; if (stat_branches !== 32'd0) $display("FAIL ar_stat_after got %0d exp 0", stat_branches); else nPass++;
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_learning();
        test_saturation();
        test_chooser();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bp_tournament.md
Name: bp_tournament

Overview:
- Parametrised tournament branch-direction predictor: gshare global predictor, two-level local predictor, and a per-index chooser.
- Prediction is combinational from the fetch-stage PC.
- The pipeline carries an opaque metadata bundle to the M stage and returns it at resolution, so tables update with the exact indices used at prediction.
- Raises mispredict/flush at resolution. Successor to the fixed-size predictor; adds real chooser-driven selection and parametrised geometry.

Parameters:
- GPHT_DEPTH, 7, log2 entries of global PHT and chooser CPHT.
- GHR_WIDTH, 4, global history bits; must be <= GPHT_DEPTH.
- BHT_DEPTH, 3, log2 entries of local history table.
- LHIST_W, 4, local history bits; local PHT has 2^LHIST_W entries.
- META_W, GPHT_DEPTH+BHT_DEPTH+LHIST_W+2, derived metadata width; not overridable.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- pc_f, in, 32: fetch PC.
- pred_taken_f, out, 1: predicted direction for pc_f.
- pred_meta_f, out, META_W: {gidx, bidx, lhist, pred_g, pred_l}; pipelined by caller.
- upd_valid, in, 1: resolved branch present in M.
- upd_taken, in, 1: actual direction.
- upd_pred, in, 1: direction predicted for that branch.
- upd_meta, in, META_W: pred_meta_f as captured at fetch.
- mispredict, out, 1: upd_valid & (upd_taken ^ upd_pred).
- flush_e, out, 1: equals mispredict; clears D->E.
- stat_branches, out, 32: see Optional Feature.
- stat_mispred, out, 32: see Optional Feature.

Behaviour:
- Index computation:
  - gidx = pc_f[GPHT_DEPTH+1:2] XOR zero-extended GHR.
  - bidx = pc_f[BHT_DEPTH+1:2].
  - lhist = BHT[bidx].
  - pred_g = GPHT[gidx][1]; pred_l = LPHT[lhist][1].
  - pred_taken_f = CPHT[gidx][1] ? pred_l : pred_g.
- All prediction paths are combinational, zero latency. Reads see pre-edge state; there is no bypass of a same-cycle update.
- Counters are 2-bit saturating: taken increments, saturating at 11; not-taken decrements, saturating at 00.
- On posedge with upd_valid=1, using upd_meta fields:
  - GPHT[gidx] and LPHT[lhist] updated toward upd_taken.
  - BHT[bidx] <= {BHT[bidx][LHIST_W-2:0], upd_taken}.
  - GHR <= {GHR[GHR_WIDTH-2:0], upd_taken}.
  - CPHT[gidx]: increment (toward local) if pred_g wrong and pred_l right; decrement if pred_l wrong and pred_g right; otherwise hold. Saturates at both ends.
- upd_valid=0: no state changes.
- mispredict and flush_e are combinational; both are 0 when upd_valid=0.
- Reset (rst=0, async, effective immediately, including mid-cycle):
  - GPHT, LPHT, CPHT all 2'b01.
  - BHT and GHR all 0.
  - Resulting outputs: pred_taken_f=0, mispredict=0, flush_e=0, stats=0.
- Updates are ignored while rst=0.
- Histories wrap by shifting out the MSB. Index arithmetic is modulo table size.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_branches increments on each upd_valid.
  - stat_mispred increments on each mispredict.
  - Both 32-bit, saturate at 0xFFFFFFFF, reset to 0.
- Undefined: both ports tied to 0 and no counter flops are inferred. The interface is unchanged either way.

Decomposition:
- Package bp_pkg:
  - counter encodings (SNT=00, WNT=01, WT=10, ST=11);
  - sat_update(cnt, taken) function;
  - packed meta struct typedef (parameterised widths passed via localparams in the module).
- One natural sub-module, bp_pht: 2^DEPTH x 2-bit counter array with one combinational read port, one synchronous saturating-update port, and async active-low reset to WNT. Instantiated three times (GPHT, LPHT, CPHT).

Test Plan:
- Reset: rst=0 then 1, pc_f=0x00400000 -> pred_taken_f=0, pred_meta_f lhist=0, mispredict=0, flush_e=0.
- Mispredict: upd_valid=1, upd_pred=0, upd_taken=1 -> mispredict=flush_e=1 same cycle; with upd_valid=0 and the same data -> both 0.
- Learning: pc_f=0x00400010 fed each cycle with its meta returned as upd_meta and upd_taken=1 -> pred_taken_f becomes 1 no later than the 6th update (GHR=1111, GPHT counter >=10); stays 1 thereafter.
- Saturation: 5 taken updates with identical upd_meta -> target GPHT entry 11; one not-taken -> 10, prediction for that meta still 1.
- Chooser: upd_meta with pred_g=0, pred_l=1, upd_taken=1 -> CPHT[gidx] 01->10; the same pc/GHR then selects pred_l; reverse case at 00 holds.
- Async reset mid-run: drop rst between edges after training -> tables and GHR cleared immediately, pred_taken_f=0; with BP_STATS_EN, stat_branches/stat_mispred read 0.
